lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit that initiates all data-memory traffic for the core. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the data-memory port (11-bit byte address, 32-bit write data, 4-bit byte mask, write enable, combinational read data). It handles byte, halfword and word accesses at any alignment, splitting accesses that cross a word boundary into two memory cycles. It returns the extracted and sign- or zero-extended load data on a one-cycle response strobe.

## Interface
- No parameters. Memory depth is fixed at 512 words, addressed by a 11-bit byte address.
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  11  byte address
- i_req_wdata  in  32  store data, right-aligned
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for word and stores
- o_rsp_valid  out  1  one-cycle completion strobe, for loads and stores
- o_rsp_rdata  out  32  extended load data; 0 for stores
- o_rsp_split  out  1  request used two memory accesses; valid with o_rsp_valid
- o_mem_addr  out  11  memory byte address, always word-aligned (bits [1:0] = 00)
- o_mem_wdata  out  32  memory write data, byte-lane positioned
- o_mem_bmask  out  4  byte-lane enables
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  32  memory read data, combinational from o_mem_addr when o_mem_wren = 0

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: o_req_ready = 1. On i_req_valid, latch the request.
  - off = addr[1:0]; base mask = 0001 / 0011 / 1111 by size.
  - mask8 (8 bits) = base << off.
  - wsh (64 bits) = wdata << (8·off), with wdata truncated to the access size first.
  - Load the memory output registers for ACC0: addr = {addr[10:2], 00}, bmask = mask8[3:0], wdata = wsh[31:0], wren = we. Go to ACC0.
- ACC0: the memory port is held.
  - Load: i_mem_rdata is captured into lo at the ending edge.
  - Store: the memory writes at the ending edge.
  - If mask8[7:4] ≠ 0: go to ACC1 with addr = {addr[10:2] + 1 (mod 512), 00}, bmask = mask8[7:4], wdata = wsh[63:32]. Word 511 wraps to word 0.
  - Otherwise go to RESP.
- ACC1: capture i_mem_rdata into hi (loads only); go to RESP.
- RESP: o_rsp_valid = 1. o_rsp_split = 1 iff ACC1 was visited. Go to IDLE.
  - Load: o_rsp_rdata = ({hi, lo} >> 8·off) truncated to size. Extend from bit 7 (byte) or bit 15 (half) unless unsigned.
  - Store: o_rsp_rdata = 0.
- In IDLE and RESP: o_mem_wren = 0 and o_mem_bmask = 0000; o_mem_addr and o_mem_wdata hold their last values.
- Loads never assert o_mem_wren, so the read data is never forced to 0 by a write cycle.
- A reset during ACC1 of a split store leaves the first word written and the second unwritten. This partial write is accepted behaviour.

## Timing
- Reset (asynchronous, immediate): state = IDLE, o_req_ready = 1, o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_split = 0, o_mem_addr = 0, o_mem_wdata = 0, o_mem_bmask = 0, o_mem_wren = 0. lo and hi are cleared.
- Cycle 0 is the cycle in which i_req_valid & o_req_ready is sampled.
  - Aligned access: ACC0 in cycle 1, o_rsp_valid in cycle 2, o_req_ready again in cycle 3.
  - Split access: ACC0 in cycle 1, ACC1 in cycle 2, o_rsp_valid in cycle 3, o_req_ready again in cycle 4.
- Throughput: one request per 3 cycles (aligned) or 4 cycles (split).
- All memory-side outputs are registered: no combinational path from a request input to a memory output.
- o_rsp_rdata is registered from lo, hi and the latched request fields.
- i_req_* are sampled only on the accept edge. The requester may change them at any other time.
- Holding i_req_valid high through RESP is legal: the next request is accepted in the first IDLE cycle, with no bubble beyond IDLE.

## Test plan
- Aligned word: SW 0x12345678 @0x010 → ACC0 drives addr 0x010, bmask 1111, wren 1. Then LW @0x010 → rdata 0x12345678, split 0, o_rsp_valid in cycle 2.
- Byte lanes: SB 0x000000AB @0x013 → bmask 1000, wdata 0xAB000000. Then LB @0x013 → 0xFFFFFFAB; LBU @0x013 → 0x000000AB.
- Misaligned word: SW 0xDEADBEEF @0x006 → ACC0 addr 0x004, bmask 1100, wdata 0xBEEF0000; ACC1 addr 0x008, bmask 0011, wdata 0x0000DEAD. Then LW @0x006 → 0xDEADBEEF, split 1, o_rsp_valid in cycle 3.
- Address wrap: word 511 = 0x80000000, word 0 = 0x000000FF. LH @0x7FF → second access addr 0x000, rdata 0xFFFFFF80; LHU @0x7FF → 0x0000FF80.
- Reset mid-split: assert i_rst_n = 0 during ACC1 of the SW @0x006 → all outputs at reset values within the same cycle, wren 0. After release, o_req_ready = 1. Word 0x008 is unchanged; word 0x004 is updated.
- Back-to-back: i_req_valid held high with LW @0x010 then SW @0x020 → o_req_ready low in cycles 1–2, second request accepted in cycle 3, o_rsp_valid pulses exactly once per request.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one request at a time, byte/half/word at any alignment,
// word-boundary crossings split into two memory cycles.
module lsu_mem_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [10:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_split,
    output logic [10:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        accept;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic [3:0]  hi_mask_q;
    logic [31:0] wsh_hi_q;
    logic [8:0]  word_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic [1:0]  req_off;
    logic [3:0]  base_mask;
    logic [7:0]  mask8;
    logic [31:0] wtrunc;
    logic [63:0] wsh;

    logic [63:0] rd64;
    logic [31:0] rd_sh;
    logic [31:0] ld_ext;

    assign accept = (state_q == IDLE) && i_req_valid;

    // Lane mask and lane-positioned write data for the incoming request
    always_comb begin
        req_off   = i_req_addr[1:0];
        base_mask = 4'b1111;
        wtrunc    = i_req_wdata;
        unique case (i_req_size)
            2'b00: begin
                base_mask = 4'b0001;
                wtrunc    = {24'h0, i_req_wdata[7:0]};
            end
            2'b01: begin
                base_mask = 4'b0011;
                wtrunc    = {16'h0, i_req_wdata[15:0]};
            end
            default: begin
                base_mask = 4'b1111;
                wtrunc    = i_req_wdata;
            end
        endcase
        mask8 = {4'b0000, base_mask} << req_off;
        wsh   = {32'h0, wtrunc} << {req_off, 3'b000};
    end

    // Align and extend load data; the word read this cycle joins the saved one
    always_comb begin
        if (state_q == ACC1) begin
            rd64 = {i_mem_rdata, lo_q};
        end else begin
            rd64 = {hi_q, i_mem_rdata};
        end
        rd_sh  = 32'(rd64 >> {off_q, 3'b000});
        ld_ext = rd_sh;
        unique case (size_q)
            2'b00: begin
                if (uns_q) ld_ext = {24'h0, rd_sh[7:0]};
                else       ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            end
            2'b01: begin
                if (uns_q) ld_ext = {16'h0, rd_sh[15:0]};
                else       ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            end
            default: ld_ext = rd_sh;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_d = ACC0;
            end
            ACC0: begin
                if (hi_mask_q != 4'b0000) state_d = ACC1;
                else                      state_d = RESP;
            end
            ACC1: state_d = RESP;
            RESP: begin
                o_rsp_valid = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, memory port registers, read capture and response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            hi_mask_q   <= 4'b0000;
            wsh_hi_q    <= 32'h0;
            word_q      <= 9'h0;
            lo_q        <= 32'h0;
            hi_q        <= 32'h0;
            o_mem_addr  <= 11'h0;
            o_mem_wdata <= 32'h0;
            o_mem_bmask <= 4'b0000;
            o_mem_wren  <= 1'b0;
            o_rsp_rdata <= 32'h0;
            o_rsp_split <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= i_req_we;
                        uns_q       <= i_req_unsigned;
                        off_q       <= req_off;
                        size_q      <= i_req_size;
                        hi_mask_q   <= mask8[7:4];
                        wsh_hi_q    <= wsh[63:32];
                        word_q      <= i_req_addr[10:2];
                        o_mem_addr  <= {i_req_addr[10:2], 2'b00};
                        o_mem_bmask <= mask8[3:0];
                        o_mem_wdata <= wsh[31:0];
                        o_mem_wren  <= i_req_we;
                    end
                end
                ACC0: begin
                    if (!we_q) lo_q <= i_mem_rdata;
                    if (hi_mask_q != 4'b0000) begin
                        o_mem_addr  <= {word_q + 9'd1, 2'b00};
                        o_mem_bmask <= hi_mask_q;
                        o_mem_wdata <= wsh_hi_q;
                    end else begin
                        o_mem_bmask <= 4'b0000;
                        o_mem_wren  <= 1'b0;
                        o_rsp_rdata <= we_q ? 32'h0 : ld_ext;
                        o_rsp_split <= 1'b0;
                    end
                end
                ACC1: begin
                    if (!we_q) hi_q <= i_mem_rdata;
                    o_mem_bmask <= 4'b0000;
                    o_mem_wren  <= 1'b0;
                    o_rsp_rdata <= we_q ? 32'h0 : ld_ext;
                    o_rsp_split <= 1'b1;
                end
                RESP: begin
                    o_rsp_rdata <= 32'h0;
                    o_rsp_split <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-lane memory model
// and a response scoreboard.
module tb_lsu_mem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [10:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_split;
    logic [10:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    lsu_mem_ctrl dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_split    (o_rsp_split),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_bmask    (o_mem_bmask),
        .o_mem_wren     (o_mem_wren),
        .i_mem_rdata    (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    bit [31:0] mem [512];
    int        cyc = 0;
    int        n_chk = 0;
    int        n_fail = 0;

    typedef struct {
        logic [31:0] rd;
        logic        sp;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    assign i_mem_rdata = o_mem_wren ? 32'h0 : mem[o_mem_addr[10:2]];

    // Memory model: byte-lane writes
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_bmask[b])
                    mem[o_mem_addr[10:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each response strobe
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_rsp_valid === 1'b1) begin
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL rsp_unexpected: observed response %h expected none",
                       o_rsp_rdata);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", o_rsp_rdata, e.rd);
                chk("rsp_split", {31'h0, o_rsp_split}, {31'h0, e.sp});
                chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_ready;
        int n;
        n = 0;
        @(negedge i_clk);
        while (o_req_ready !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (o_req_ready !== 1'b1) chk("ready_timeout", {31'h0, o_req_ready}, 32'h1);
    endtask

    task automatic drive(input logic we, input logic [10:0] a,
                         input logic [31:0] wd, input logic [1:0] sz,
                         input logic un);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = a;
        i_req_wdata    = wd;
        i_req_size     = sz;
        i_req_unsigned = un;
    endtask

    task automatic do_req(input logic we, input logic [10:0] a,
                          input logic [31:0] wd, input logic [1:0] sz,
                          input logic un, input logic [31:0] er,
                          input logic es, input bit chkm,
                          input logic [10:0] a0, input logic [3:0] m0,
                          input logic [31:0] w0, input logic [10:0] a1,
                          input logic [3:0] m1, input logic [31:0] w1);
        exp_t e;
        wait_ready();
        drive(we, a, wd, sz, un);
        e.rd  = er;
        e.sp  = es;
        e.lat = es ? 3 : 2;
        e.acc = cyc;
        sb.push_back(e);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        if (chkm) begin
            chk("acc0_addr", {21'h0, o_mem_addr}, {21'h0, a0});
            chk("acc0_bmask", {28'h0, o_mem_bmask}, {28'h0, m0});
            chk("acc0_wdata", o_mem_wdata, w0);
            chk("acc0_wren", {31'h0, o_mem_wren}, {31'h0, we});
            if (es) begin
                @(negedge i_clk);
                chk("acc1_addr", {21'h0, o_mem_addr}, {21'h0, a1});
                chk("acc1_bmask", {28'h0, o_mem_bmask}, {28'h0, m1});
                chk("acc1_wdata", o_mem_wdata, w1);
                chk("acc1_wren", {31'h0, o_mem_wren}, {31'h0, we});
            end
        end
    endtask

    task automatic ld(input logic [10:0] a, input logic [1:0] sz,
                      input logic un, input logic [31:0] er, input logic es);
        do_req(1'b0, a, 32'h0, sz, un, er, es, 1'b0,
               11'h0, 4'h0, 32'h0, 11'h0, 4'h0, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, o_req_ready}, 32'h1);
        chk({tag, "_rsp_valid"}, {31'h0, o_rsp_valid}, 32'h0);
        chk({tag, "_rsp_rdata"}, o_rsp_rdata, 32'h0);
        chk({tag, "_rsp_split"}, {31'h0, o_rsp_split}, 32'h0);
        chk({tag, "_mem_addr"}, {21'h0, o_mem_addr}, 32'h0);
        chk({tag, "_mem_wdata"}, o_mem_wdata, 32'h0);
        chk({tag, "_mem_bmask"}, {28'h0, o_mem_bmask}, 32'h0);
        chk({tag, "_mem_wren"}, {31'h0, o_mem_wren}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        i_rst_n = 1'b0;
        drive(1'b0, 11'h0, 32'h0, 2'b00, 1'b0);
        i_req_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("reset");
        i_rst_n = 1'b1;

        // Aligned word
        do_req(1'b1, 11'h010, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1,
               11'h010, 4'b1111, 32'h12345678, 11'h0, 4'h0, 32'h0);
        ld(11'h010, 2'b10, 1'b0, 32'h12345678, 1'b0);

        // Byte lanes
        do_req(1'b1, 11'h013, 32'h000000AB, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1,
               11'h010, 4'b1000, 32'hAB000000, 11'h0, 4'h0, 32'h0);
        ld(11'h013, 2'b00, 1'b0, 32'hFFFFFFAB, 1'b0);
        ld(11'h013, 2'b00, 1'b1, 32'h000000AB, 1'b0);

        // Misaligned word
        do_req(1'b1, 11'h006, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1,
               11'h004, 4'b1100, 32'hBEEF0000, 11'h008, 4'b0011, 32'h0000DEAD);
        ld(11'h006, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1);
        ld(11'h004, 2'b10, 1'b0, 32'hBEEF0000, 1'b0);
        ld(11'h008, 2'b10, 1'b0, 32'h0000DEAD, 1'b0);

        // Address wrap
        do_req(1'b1, 11'h7FC, 32'h80000000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0,
               11'h0, 4'h0, 32'h0, 11'h0, 4'h0, 32'h0);
        do_req(1'b1, 11'h000, 32'h000000FF, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0,
               11'h0, 4'h0, 32'h0, 11'h0, 4'h0, 32'h0);
        do_req(1'b0, 11'h7FF, 32'h0, 2'b01, 1'b0, 32'hFFFFFF80, 1'b1, 1'b1,
               11'h7FC, 4'b1000, 32'h0, 11'h000, 4'b0001, 32'h0);
        ld(11'h7FF, 2'b01, 1'b1, 32'h0000FF80, 1'b1);

        // Reset in ACC1 of a split store
        wait_ready();
        drive(1'b1, 11'h006, 32'hCAFEF00D, 2'b10, 1'b0);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(posedge i_clk);
        #2;
        chk("mid_acc1_addr", {21'h0, o_mem_addr}, 32'h008);
        chk("mid_acc1_wren", {31'h0, o_mem_wren}, 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'h0, o_req_ready}, 32'h1);
        ld(11'h004, 2'b10, 1'b0, 32'hF00D0000, 1'b0);
        ld(11'h008, 2'b10, 1'b0, 32'h0000DEAD, 1'b0);

        // Back-to-back with valid held high
        wait_ready();
        drive(1'b0, 11'h010, 32'h0, 2'b10, 1'b0);
        e.rd = 32'hAB345678; e.sp = 1'b0; e.lat = 2; e.acc = cyc;
        sb.push_back(e);
        @(posedge i_clk);
        #1 drive(1'b1, 11'h020, 32'h55AA55AA, 2'b10, 1'b0);
        @(negedge i_clk);
        chk("b2b_ready_c1", {31'h0, o_req_ready}, 32'h0);
        @(negedge i_clk);
        chk("b2b_ready_c2", {31'h0, o_req_ready}, 32'h0);
        @(negedge i_clk);
        chk("b2b_ready_c3", {31'h0, o_req_ready}, 32'h1);
        e.rd = 32'h0; e.sp = 1'b0; e.lat = 2; e.acc = cyc;
        sb.push_back(e);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        ld(11'h020, 2'b10, 1'b0, 32'h55AA55AA, 1'b0);

        repeat (6) @(negedge i_clk);
        chk("sb_drained", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
